// File: rtl/mem_pkg.sv
// +----------------------------------------------------------------------------+
// | mem_pkg : shared types for the RV32I memory stage (widths, result source,  |
// |           FSM states, timeout counter sizing)                              |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package mem_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } width_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } res_src_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Bits needed to count 0 .. cycles-1 (at least one bit).
  function automatic int cnt_width(input int cycles);
    int w;
    w = 1;
    while ((1 << w) < cycles) w++;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_align.sv
// +----------------------------------------------------------------------------+
// | mem_align : byte-enable / store-lane replication and load extension        |
// | Rev 1.0   : initial release                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_width,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata_ext
);

  logic [7:0]  w_lane_b;
  logic [15:0] w_lane_h;

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    case (i_width)
      F3_B, F3_BU: begin
        o_be    = 4'b0001 << i_addr;
        o_wdata = {4{i_wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        o_be    = 4'b0011 << {i_addr[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
    endcase
  end

  always_comb begin
    w_lane_b = i_rdata[7:0];
    case (i_addr)
      2'd1:    w_lane_b = i_rdata[15:8];
      2'd2:    w_lane_b = i_rdata[23:16];
      2'd3:    w_lane_b = i_rdata[31:24];
      default: w_lane_b = i_rdata[7:0];
    endcase
    w_lane_h = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  // Undefined width codes fall through to the full-word path.
  always_comb begin
    o_rdata_ext = i_rdata;
    case (i_width)
      F3_B:    o_rdata_ext = {{24{w_lane_b[7]}}, w_lane_b};
      F3_BU:   o_rdata_ext = {24'd0, w_lane_b};
      F3_H:    o_rdata_ext = {{16{w_lane_h[15]}}, w_lane_h};
      F3_HU:   o_rdata_ext = {16'd0, w_lane_h};
      default: o_rdata_ext = i_rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// +----------------------------------------------------------------------------+
// | mem_stage : RV32I memory stage - data-memory handshake, stall, timeout     |
// |             abort and MEM/WB register. Option: MEM_MISALIGN_TRAP_EN        |
// | Rev 1.0   : initial release                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemWriteM,
  input  logic [2:0]  DataWidthM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [5:0]  RDM,
  input  logic [31:0] PCPlus4M,
  output logic        DReq,
  output logic        DWe,
  output logic [31:0] DAddr,
  output logic [3:0]  DBe,
  output logic [31:0] DWData,
  input  logic [31:0] DRData,
  input  logic        DAck,
  output logic        StallM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [5:0]  RDW,
  output logic [31:0] PCPlus4W,
  output logic        BusErrW
);

  localparam int                 c_CNT_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [c_CNT_W-1:0] r_count;

  logic        w_access;
  logic        w_trap;
  logic        w_req;
  logic        w_ack;
  logic        w_timeout;
  logic        w_stall;
  logic [31:0] w_rdata_ext;

  mem_align u_align (
    .i_addr      (ALUOutM[1:0]),
    .i_width     (DataWidthM),
    .i_wdata     (WriteDataM),
    .i_rdata     (DRData),
    .o_be        (DBe),
    .o_wdata     (DWData),
    .o_rdata_ext (w_rdata_ext)
  );

  assign w_access = MemWriteM | (ResultSrcM == RES_MEM);

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    w_trap = 1'b0;
    case (DataWidthM)
      F3_B, F3_BU: w_trap = 1'b0;
      F3_H, F3_HU: w_trap = w_access & ALUOutM[0];
      default:     w_trap = w_access & (|ALUOutM[1:0]);
    endcase
  end
`else
  assign w_trap = 1'b0;
`endif

  // While waiting, EX/MEM is frozen so the request keeps its attributes.
  assign w_req     = rst_n & ((r_state == ST_WAIT) | (w_access & ~w_trap));
  assign w_ack     = DAck & w_req;
  assign w_timeout = (r_state == ST_WAIT) & (r_count == c_CNT_LAST) & ~w_ack;
  assign w_stall   = w_req & ~w_ack & ~w_timeout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_req & ~w_ack)      w_state_nxt = ST_WAIT;
      ST_WAIT: if (w_ack | w_timeout)   w_state_nxt = ST_IDLE;
      default:                          w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    DReq   = w_req;
    DWe    = w_req & MemWriteM;
    DAddr  = {ALUOutM[31:2], 2'b00};
    StallM = w_stall;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || r_state == ST_IDLE) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  // Stalled edges insert a bubble; aborted accesses retire without a write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      ReadDataW  <= 32'd0;
      ALUOutW    <= 32'd0;
      RDW        <= 6'd0;
      PCPlus4W   <= 32'd0;
      BusErrW    <= 1'b0;
    end else if (w_stall) begin
      RegWriteW  <= 1'b0;
      BusErrW    <= 1'b0;
    end else begin
      RegWriteW  <= RegWriteM & ~w_timeout & ~w_trap;
      BusErrW    <= w_timeout | w_trap;
      ResultSrcW <= ResultSrcM;
      ALUOutW    <= ALUOutM;
      RDW        <= RDM;
      PCPlus4W   <= PCPlus4M;
      if (w_ack) begin
        ReadDataW <= w_rdata_ext;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops push expected W-stage values,
// a negedge monitor pops one entry per retiring (non-stalled) edge.
`default_nettype none

module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWriteM, MemWriteM, DAck;
  logic [1:0]  ResultSrcM;
  logic [2:0]  DataWidthM;
  logic [31:0] ALUOutM, WriteDataM, PCPlus4M, DRData;
  logic [5:0]  RDM;
  logic        DReq, DWe, StallM, RegWriteW, BusErrW;
  logic [31:0] DAddr, DWData, ReadDataW, ALUOutW, PCPlus4W;
  logic [3:0]  DBe;
  logic [1:0]  ResultSrcW;
  logic [5:0]  RDW;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .MemWriteM(MemWriteM), .DataWidthM(DataWidthM), .ALUOutM(ALUOutM),
    .WriteDataM(WriteDataM), .RDM(RDM), .PCPlus4M(PCPlus4M), .DReq(DReq),
    .DWe(DWe), .DAddr(DAddr), .DBe(DBe), .DWData(DWData), .DRData(DRData),
    .DAck(DAck), .StallM(StallM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .RDW(RDW), .PCPlus4W(PCPlus4W),
    .BusErrW(BusErrW)
  );

  typedef struct {
    logic        rw;
    logic [1:0]  rs;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [5:0]  rd;
    logic [31:0] pc4;
    logic        berr;
  } wexp_t;

  wexp_t q[$];
  int    checks = 0;
  int    errors = 0;
  logic  pend   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a non-stalled edge with reset high retires one entry.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend && q.size() > 0) begin
        wexp_t e;
        e = q.pop_front();
        chk("RegWriteW",  {31'd0, RegWriteW}, {31'd0, e.rw});
        chk("ResultSrcW", {30'd0, ResultSrcW}, {30'd0, e.rs});
        chk("ReadDataW",  ReadDataW, e.rdata);
        chk("ALUOutW",    ALUOutW, e.alu);
        chk("RDW",        {26'd0, RDW}, {26'd0, e.rd});
        chk("PCPlus4W",   PCPlus4W, e.pc4);
        chk("BusErrW",    {31'd0, BusErrW}, {31'd0, e.berr});
      end
      pend = !StallM;
    end
  end

  task automatic check_w_zero();
    chk("rst RegWriteW",  {31'd0, RegWriteW}, 32'd0);
    chk("rst ResultSrcW", {30'd0, ResultSrcW}, 32'd0);
    chk("rst ReadDataW",  ReadDataW, 32'd0);
    chk("rst ALUOutW",    ALUOutW, 32'd0);
    chk("rst RDW",        {26'd0, RDW}, 32'd0);
    chk("rst PCPlus4W",   PCPlus4W, 32'd0);
    chk("rst BusErrW",    {31'd0, BusErrW}, 32'd0);
  endtask

  // Called at posedge+1; ackd = cycle index at which DAck is raised (-1 never).
  task automatic op(input logic rw, input logic [1:0] rs, input logic we,
                    input logic [2:0] w, input logic [31:0] a, input logic [31:0] wd,
                    input logic [5:0] rd, input logic [31:0] pc4, input int ackd,
                    input logic [31:0] rdata, input logic [31:0] exp_rdw,
                    input logic exp_berr, input int exp_stall,
                    input logic [3:0] exp_be, input logic [31:0] exp_wd);
    wexp_t e;
    logic  acc, stall_now, done;
    int    stalls;
    RegWriteM = rw; ResultSrcM = rs; MemWriteM = we; DataWidthM = w;
    ALUOutM = a; WriteDataM = wd; RDM = rd; PCPlus4M = pc4; DRData = rdata;
    e.rw = rw & ~exp_berr; e.rs = rs; e.rdata = exp_rdw; e.alu = a;
    e.rd = rd; e.pc4 = pc4; e.berr = exp_berr;
    q.push_back(e);
    acc = we | (rs == 2'b01);
    stalls = 0;
    done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      DAck = (n == ackd);
      #1;
      if (n == 0) begin
        chk("DReq", {31'd0, DReq}, {31'd0, acc});
        if (acc) begin
          chk("DWe",    {31'd0, DWe}, {31'd0, we});
          chk("DAddr",  DAddr, {a[31:2], 2'b00});
          chk("DBe",    {28'd0, DBe}, {28'd0, exp_be});
          chk("DWData", DWData, exp_wd);
        end
      end
      stall_now = StallM;
      @(posedge clk);
      #1;
      if (!stall_now) begin
        done = 1'b1;
        break;
      end
      stalls++;
    end
    DAck = 1'b0;
    chk("op completes within bound", {31'd0, done}, 32'd1);
    chk("stall cycles", stalls, exp_stall);
  endtask

  initial begin
    rst_n = 1'b0; DAck = 1'b0; DRData = 32'd0;
    RegWriteM = 1'b0; ResultSrcM = 2'b00; MemWriteM = 1'b0; DataWidthM = 3'b010;
    ALUOutM = 32'd0; WriteDataM = 32'd0; RDM = 6'd0; PCPlus4M = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst DReq", {31'd0, DReq}, 32'd0);
    check_w_zero();
    rst_n = 1'b1;

    //  rw    rs     we    w       addr          wdata         rd     pc4        ackd rdata         exp_rdw       berr stall be       wdata
    op(1'b1, 2'b00, 1'b0, 3'b010, 32'h0000_1234, 32'h0,        6'd5,  32'h1004, -1, 32'h0,        32'h0,        1'b0, 0, 4'b1111, 32'h0);
    op(1'b0, 2'b00, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 6'd0, 32'h1008,  0, 32'h0,        32'h0,        1'b0, 0, 4'b1000, 32'hABAB_ABAB);
    op(1'b1, 2'b01, 1'b0, 3'b000, 32'h0000_0102, 32'h1122_3344, 6'd7, 32'h100C,  3, 32'h0080_0000, 32'hFFFF_FF80, 1'b0, 3, 4'b0100, 32'h4444_4444);
    op(1'b1, 2'b01, 1'b0, 3'b100, 32'h0000_0102, 32'h1122_3344, 6'd8, 32'h1010,  0, 32'h0080_0000, 32'h0000_0080, 1'b0, 0, 4'b0100, 32'h4444_4444);
    op(1'b1, 2'b01, 1'b0, 3'b101, 32'h0000_0202, 32'h1122_3344, 6'd9, 32'h1014,  1, 32'hBEEF_0000, 32'h0000_BEEF, 1'b0, 1, 4'b1100, 32'h3344_3344);
    op(1'b1, 2'b01, 1'b0, 3'b001, 32'h0000_0202, 32'h1122_3344, 6'd10, 32'h1018, 0, 32'hBEEF_0000, 32'hFFFF_BEEF, 1'b0, 0, 4'b1100, 32'h3344_3344);
    op(1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0300, 32'h1122_3344, 6'd11, 32'h101C, 0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 0, 4'b1111, 32'h1122_3344);
    op(1'b0, 2'b00, 1'b1, 3'b001, 32'h0000_0402, 32'h1234_ABCD, 6'd0, 32'h1020,  2, 32'h0,        32'h0,        1'b0, 2, 4'b1100, 32'hABCD_ABCD);
    op(1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0305, 32'h0,        6'd12, 32'h1024,  0, 32'h0102_0304, 32'h0102_0304, 1'b0, 0, 4'b1111, 32'h0);
    // Timeout: four stalled cycles, then an aborted retire with BusErrW.
    op(1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0500, 32'h0,        6'd9,  32'h2000, -1, 32'h0000_5555, 32'h0102_0304, 1'b1, 4, 4'b1111, 32'h0);
    op(1'b0, 2'b00, 1'b0, 3'b010, 32'h0000_0000, 32'h0,        6'd0,  32'h0,    -1, 32'h0,        32'h0102_0304, 1'b0, 0, 4'b1111, 32'h0);

    // Reset in the middle of a WAIT, then a late DAck.
    RegWriteM = 1'b1; ResultSrcM = 2'b01; MemWriteM = 1'b0; DataWidthM = 3'b010;
    ALUOutM = 32'h600; RDM = 6'd13; PCPlus4M = 32'h3000; DRData = 32'h7777_7777;
    repeat (2) @(posedge clk);
    #1;
    chk("WAIT StallM", {31'd0, StallM}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst DReq forced", {31'd0, DReq}, 32'd0);
    chk("rst StallM forced", {31'd0, StallM}, 32'd0);
    @(posedge clk);
    #1;
    check_w_zero();
    rst_n = 1'b1;
    op(1'b0, 2'b00, 1'b0, 3'b010, 32'h0000_0040, 32'h0,        6'd3,  32'h44,    0, 32'h7777_7777, 32'h0,        1'b0, 0, 4'b1111, 32'h0);
    chk("post-reset RegWriteW", {31'd0, RegWriteW}, 32'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
